// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, default reset/trap vectors
// and the fetch sequencer state encoding.
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h0000_0000;
   localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'h0000_0180;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory req/ack channel and
// the valid/ready instruction channel towards decode.
//   master : the fetch unit (drives req/addr, instr/instr_valid)
//   slave  : memory + decode side (drives ack/rdata, instr_ready)
interface pc_fetch_unit_if;
   import cpu_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;

   logic [XLEN-1:0] instr;
   logic            instr_valid;
   logic            instr_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata,
      output instr,
      output instr_valid,
      input  instr_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata,
      input  instr,
      input  instr_valid,
      output instr_ready
   );

endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer (IDLE/FETCH/HOLD).
// Ports: clk, rst (sync, active-high), next_pc, stall, pc,
// pc_plus4, exc, exc_epc, bus (pc_fetch_unit_if.master).
// Optional macro PC_ALIGN_CHECK_EN: trap on misaligned targets.
module pc_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] next_pc,
   input  logic            stall,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            exc,
   output logic [XLEN-1:0] exc_epc,
   pc_fetch_unit_if.master bus
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic            valid_q, valid_d;
   logic            exc_d;
   logic [XLEN-1:0] epc_d;
   logic            advance;

   assign advance = (state_q == HOLD)
                 && bus.instr_ready
                 && !stall;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      exc_d   = 1'b0;
      epc_d   = exc_epc;
      unique case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (bus.imem_ack) begin
               instr_d = bus.imem_rdata;
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (advance) begin
               valid_d = 1'b0;
               state_d = FETCH;
`ifdef PC_ALIGN_CHECK_EN
               if (next_pc[1:0] != 2'b00) begin
                  pc_d  = EXC_VECTOR;
                  epc_d = next_pc;
                  exc_d = 1'b1;
               end else begin
                  pc_d = next_pc;
               end
`else
               pc_d = {next_pc[XLEN-1:2], 2'b00};
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic            exc_q;
   logic [XLEN-1:0] epc_q;

   // exc_d is only set on the advance edge, and the FSM then
   // sits in FETCH, so exc_q is a single-cycle pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         exc_q <= 1'b0;
         epc_q <= '0;
      end else begin
         exc_q <= exc_d;
         epc_q <= epc_d;
      end
   end

   assign exc     = exc_q;
   assign exc_epc = epc_q;
`else
   // Alignment is forced instead of trapped; keep the trap
   // inputs referenced so the default build stays warning-free.
   logic unused_cfg;
   assign unused_cfg = ^{EXC_VECTOR, next_pc[1:0],
                         exc_d, epc_d};

   assign exc     = 1'b0;
   assign exc_epc = '0;
`endif

   assign pc            = pc_q;
   assign pc_plus4      = pc_q + 32'd4;
   assign bus.imem_req  = (state_q == FETCH);
   assign bus.imem_addr = pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
// Memory returns address ^ A5A5A5A5 as the instruction word.
module tb_pc_fetch_unit;
   import cpu_pkg::*;

   localparam logic [31:0] KEY = 32'hA5A5_A5A5;

   logic        clk;
   logic        rst;
   logic [31:0] next_pc;
   logic        stall;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        exc;
   logic [31:0] exc_epc;

   logic        ack_v;
   logic        ready_v;
   logic        follow;
   logic [31:0] np_v;

   int checks;
   int failures;

   pc_fetch_unit_if bus ();

   assign bus.imem_ack    = ack_v;
   assign bus.imem_rdata  = bus.imem_addr ^ KEY;
   assign bus.instr_ready = ready_v;
   assign next_pc = follow ? pc_plus4 : np_v;

   pc_fetch_unit dut (
      .clk      (clk),
      .rst      (rst),
      .next_pc  (next_pc),
      .stall    (stall),
      .pc       (pc),
      .pc_plus4 (pc_plus4),
      .exc      (exc),
      .exc_epc  (exc_epc),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst     = 1'b1;
      ack_v   = 1'b1;
      ready_v = 1'b1;
      stall   = 1'b0;
      follow  = 1'b1;
      np_v    = '0;

      // reset for two cycles
      tick();
      tick();
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
      chk("rst_instr", bus.instr, 32'h0);
      chk("rst_exc", {31'b0, exc}, 32'h0);
      chk("rst_epc", exc_epc, 32'h0);

      // IDLE cycle after release
      rst = 1'b0;
      chk("idle_req", {31'b0, bus.imem_req}, 32'h0);
      tick();
      chk("first_req", {31'b0, bus.imem_req}, 32'h1);
      chk("first_addr", bus.imem_addr, 32'h0);
      tick();
      chk("first_valid", {31'b0, bus.instr_valid}, 32'h1);
      chk("first_instr", bus.instr, 32'h0 ^ KEY);

      // sequential stream, 2 cycles per instruction
      for (int i = 1; i < 4; i++) begin
         tick();
         chk("seq_req", {31'b0, bus.imem_req}, 32'h1);
         chk("seq_addr", bus.imem_addr, 32'(4 * i));
         chk("seq_vlow", {31'b0, bus.instr_valid}, 32'h0);
         tick();
         chk("seq_instr", bus.instr, 32'(4 * i) ^ KEY);
         chk("seq_valid", {31'b0, bus.instr_valid}, 32'h1);
      end

      // decode backpressure: 4 cycles not ready
      ready_v = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_pc", pc, 32'hC);
         chk("bp_instr", bus.instr, 32'hC ^ KEY);
         chk("bp_valid", {31'b0, bus.instr_valid}, 32'h1);
      end

      // hazard stall with ready high
      ready_v = 1'b1;
      stall   = 1'b1;
      tick();
      chk("stall_pc", pc, 32'hC);
      chk("stall_valid", {31'b0, bus.instr_valid}, 32'h1);
      stall = 1'b0;

      // memory wait states: ack held off for 3 cycles
      ack_v = 1'b0;
      tick();
      chk("ws_addr0", bus.imem_addr, 32'h10);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ws_req", {31'b0, bus.imem_req}, 32'h1);
         chk("ws_addr", bus.imem_addr, 32'h10);
         chk("ws_valid", {31'b0, bus.instr_valid}, 32'h0);
      end
      ack_v = 1'b1;
      tick();
      chk("ws_instr", bus.instr, 32'h10 ^ KEY);
      chk("ws_valid1", {31'b0, bus.instr_valid}, 32'h1);

      // branch redirect
      follow = 1'b0;
      np_v   = 32'h0000_0040;
      tick();
      chk("br_addr", bus.imem_addr, 32'h40);
      chk("br_plus4", pc_plus4, 32'h44);
      tick();
      chk("br_instr", bus.instr, 32'h40 ^ KEY);

      // PC wrap
      np_v = 32'hFFFF_FFFC;
      tick();
      chk("wrap_pc", pc, 32'hFFFF_FFFC);
      chk("wrap_plus4", pc_plus4, 32'h0);
      chk("wrap_exc", {31'b0, exc}, 32'h0);
      tick();

      // misaligned target
      np_v = 32'h0000_0102;
      tick();
`ifdef PC_ALIGN_CHECK_EN
      chk("mis_exc", {31'b0, exc}, 32'h1);
      chk("mis_epc", exc_epc, 32'h102);
      chk("mis_addr", bus.imem_addr, 32'h180);
`else
      chk("mis_exc", {31'b0, exc}, 32'h0);
      chk("mis_epc", exc_epc, 32'h0);
      chk("mis_addr", bus.imem_addr, 32'h100);
`endif
      tick();
      chk("mis_exc_end", {31'b0, exc}, 32'h0);

      // reset while FETCH waits on ack
      np_v = 32'h0000_0200;
      tick();
      ack_v = 1'b0;
      tick();
      chk("rf_req", {31'b0, bus.imem_req}, 32'h1);
      chk("rf_addr", bus.imem_addr, 32'h200);
      rst   = 1'b1;
      ack_v = 1'b1;
      tick();
      chk("rf_pc", pc, 32'h0);
      chk("rf_valid", {31'b0, bus.instr_valid}, 32'h0);
      chk("rf_instr", bus.instr, 32'h0);
      chk("rf_idle", {31'b0, bus.imem_req}, 32'h0);
      rst = 1'b0;
      tick();
      chk("rf_req2", {31'b0, bus.imem_req}, 32'h1);
      chk("rf_addr2", bus.imem_addr, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and instruction-fetch sequencer for the CPU. It holds the current PC, produces PC+4 for the x0 input of the next-PC 4:1 select mux, and consumes that mux's 32-bit result as `next_pc`. It issues one request per instruction to instruction memory with a req/ack handshake, and holds the fetched word in a valid/ready output register for decode.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `EXC_VECTOR`, 32'h0000_0180: PC loaded on a misaligned-target trap. Used only when `PC_ALIGN_CHECK_EN` is defined.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `next_pc`  in  32  output of the next-PC 4:1 select mux.
- `stall`  in  1  hazard hold; while high, the PC does not advance.
- `pc`  out  32  current PC (registered).
- `pc_plus4`  out  32  combinational `pc + 4`, modulo 2^32.
- `imem_req`  out  1  fetch request; combinational, equal to state == FETCH.
- `imem_addr`  out  32  equals `pc`.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  registered instruction for decode.
- `instr_valid`  out  1  `instr` holds a valid word.
- `instr_ready`  in  1  decode accepts `instr` this cycle.
- `exc`  out  1  one-cycle misaligned-target trap pulse.
- `exc_epc`  out  32  offending target address, captured when `exc` is raised.

## Operation

- States are IDLE, FETCH and HOLD.
- Reset values:
  - state = IDLE, `pc` = `RESET_PC`.
  - `instr` = 0, `instr_valid` = 0.
  - `exc` = 0, `exc_epc` = 0.
  - `imem_req` = 0.
- IDLE → FETCH unconditionally on the next cycle.
- FETCH:
  - `imem_req` = 1 and `imem_addr` = `pc`.
  - On `imem_ack`: `instr` ← `imem_rdata`, `instr_valid` ← 1, go to HOLD.
  - Without `imem_ack`: remain in FETCH with address stable.
  - `stall` has no effect in FETCH.
- HOLD: advance when `instr_ready` && !`stall`:
  - `pc` ← `next_pc`.
  - `instr_valid` ← 0.
  - Go to FETCH.
- HOLD: otherwise hold all registers.
- `imem_ack` outside FETCH is ignored. After `rst`, the memory must not return an ack for a request that was aborted by the reset.
- Reset mid-operation takes priority over every other event in the same cycle, including an ack or an advance.
- PC wrap: at `pc` = 32'hFFFF_FFFC, `pc_plus4` = 32'h0000_0000, and no flag is raised.

## Timing

- `imem_ack` in the same cycle as the request gives a 2-cycle minimum per instruction: FETCH, then HOLD.
- `instr_valid` rises the cycle after the ack edge and stays high until the advance edge.
- `pc` changes only on an advance edge, a trap, or reset.
- The first `imem_req` is asserted in the second cycle after `rst` deasserts (IDLE lasts one cycle).
- `pc_plus4` follows `pc` combinationally in the same cycle.

## Configuration

Macro `PC_ALIGN_CHECK_EN`:
- Defined:
  - On an advance with `next_pc[1:0]` ≠ 0: `pc` ← `EXC_VECTOR`, `exc_epc` ← `next_pc`, `exc` = 1 for exactly one cycle (the cycle after the edge), then go to FETCH.
- Undefined:
  - `pc` ← {`next_pc[31:2]`, 2'b00}.
  - `exc` is tied to 0 and `exc_epc` is tied to 0.
- The ports exist in both builds.

## Structure

- Shared package `cpu_pkg` holds:
  - word width constant (32);
  - `RESET_PC` and `EXC_VECTOR` default constants;
  - fetch-state enum `fetch_state_t` (IDLE, FETCH, HOLD).
- No sub-module: the FSM, PC register and output register are small enough to live in one module.
- The next-PC 4:1 mux stays a separate module outside this block.

## Test plan

- Reset and first fetch: `rst` high for 2 cycles, then low, with `imem_ack` = 1 always. Required:
  - `imem_req` = 0 in the IDLE cycle.
  - `imem_req` = 1 with `imem_addr` = 0 in the next cycle.
  - `instr_valid` = 1 one cycle later.
- Sequential stream: `next_pc` driven from `pc_plus4`, `instr_ready` = 1, ack always high, `imem_rdata` = address XOR 32'hA5A5_A5A5. Required:
  - `instr` sequence is 0^A5A5A5A5, 4^A5A5A5A5, 8^A5A5A5A5, …
  - one instruction every 2 cycles.
- Wait states and backpressure:
  - ack delayed 3 cycles → `imem_req` and `imem_addr` held stable for the whole wait.
  - `instr_ready` = 0 for 4 cycles → `instr` and `pc` held.
  - `stall` = 1 in HOLD with `instr_ready` = 1 → no advance.
- Branch redirect: `next_pc` = 32'h0000_0040 at the advance edge → next `imem_addr` = 32'h40. Wrap case: `pc` = 32'hFFFF_FFFC → `pc_plus4` = 0.
- Misaligned target, `next_pc` = 32'h0000_0102:
  - With `PC_ALIGN_CHECK_EN`: `exc` pulses 1 cycle, `exc_epc` = 32'h102, next `imem_addr` = 32'h180.
  - Without it: next `imem_addr` = 32'h100 and `exc` stays 0.
- Reset mid-fetch: assert `rst` in a cycle where FETCH is waiting on `imem_ack`. Required:
  - next cycle state = IDLE, `pc` = `RESET_PC`, `instr_valid` = 0.
  - the ack presented in the reset cycle has no effect.
